// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 32'd4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;

    // Largest decimal value representable in the given number of BCD digits.
    function automatic longint unsigned bcd_max_val(input int digits);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                          start;
    logic [BIN_W-1:0]              bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic                          overflow;

    modport master (output start, bin, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
    import bin_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Digit correction ahead of the shift.
    always_comb begin
        if (din >= ADD3_THRESH) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
// Results are held on bcd_out/overflow between conversions.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
)(
    input  logic            clk,
    input  logic            rst_n,
    bin_to_bcd_seq_if.slave bus
);

    localparam int              BCD_W    = BCD_DIGIT_W * DIGITS;
    localparam int              WORK_W   = BCD_W + BIN_W;
    localparam int              CNT_W    = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_DEC  = bcd_max_val(DIGITS);
    localparam int              DEC_W    = $clog2(MAX_DEC + 64'd1);
    localparam int              CMP_W    = (BIN_W > DEC_W) ? BIN_W : DEC_W;
    localparam logic [CMP_W-1:0] MAX_CMP = CMP_W'(MAX_DEC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WORK_W-1:0]  work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_pend_r;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_out_r;
    logic               overflow_r;

    logic               accept_s;
    logic               last_s;
    logic [CMP_W-1:0]   bin_ext_s;
    logic [BCD_W-1:0]   corr_s;
    logic [WORK_W-1:0]  shifted_s;
    logic               carry_s;

    assign bin_ext_s = CMP_W'(bus.bin);

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (work_r[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .dout (corr_s[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    // A carry out of the top digit only happens for out-of-range inputs.
    assign {carry_s, shifted_s} = {corr_s, work_r[BIN_W-1:0], 1'b0};

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Work register, iteration counter and pending overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_r     <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
        end else if (accept_s) begin
            work_r     <= WORK_W'(bus.bin);
            cnt_r      <= '0;
            ovf_pend_r <= (bin_ext_s > MAX_CMP);
        end else if (state_r == ST_SHIFT) begin
            work_r <= shifted_s;
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            work_r <= work_r;
        end
    end

    // Registered handshake and result; the result only moves on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_out_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= last_s;
            if (last_s) begin
                bcd_out_r  <= (ovf_pend_r || carry_s) ? ALL_NINES
                                                      : shifted_s[WORK_W-1 -: BCD_W];
                overflow_r <= ovf_pend_r;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcd_out  = bcd_out_r;
    assign bus.overflow = overflow_r;

endmodule
